decode_exec_unit: RTL and testbench
===================================

DECODE_EXEC_UNIT -- requirements
Module: decode_exec_unit

Interface
REQ-001 SHALL have no parameters; data path 64 bits, 32 architectural registers, fixed.
REQ-002 clk  in  1  sole clock, rising-edge.
REQ-003 reset  in  1  asynchronous, active-low reset (0 = reset).
REQ-004 instr_valid  in  1  instruction present this cycle.
REQ-005 instruction  in  32  RV64I instruction word.
REQ-006 pc  in  64  address of instruction (AUIPC only).
REQ-007 dbg_addr  in  5  debug register read index.
REQ-008 dbg_data  out  64  combinational value of register dbg_addr.
REQ-009 rd, rs1, rs2  out  5 each  decoded fields, instruction[11:7], [19:15], [24:20].
REQ-010 immediate  out  32  signed decoded immediate (I- or U-type per opcode, else 0).
REQ-011 alu_op  out  11  {instruction[30], funct3, opcode}.
REQ-012 shamt  out  6  instruction[25:20].
REQ-013 result  out  64  combinational ALU result.
REQ-014 wr_en  out  1  register write occurs at next rising edge.
REQ-015 illegal  out  1  instr_valid with unsupported encoding.

Function
REQ-016 Decode, register read and ALU SHALL be combinational; write-back SHALL occur at the rising edge of the cycle with instr_valid=1 (latency 1 cycle to architectural state).
REQ-017 wr_en SHALL = instr_valid & legal & rd!=0 & reset=1.
REQ-018 x0 SHALL read as 0 always; writes to x0 are dropped.
REQ-019 OP-IMM (0010011): ADDI, SLTI, SLTIU, XORI, ORI, ANDI with sign-extended 12-bit imm; SLLI/SRLI/SRAI use 6-bit shamt; instruction[31:26] other than 000000 (010000 for SRAI) SHALL be illegal.
REQ-020 OP (0110011): ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND; shift amount = rs2 value [5:0]; funct7 other than 0000000/0100000 (latter only for SUB/SRA) SHALL be illegal.
REQ-021 LUI (0110111): result = sign-extend(imm20<<12) to 64; AUIPC (0010111): result = pc + that value.
REQ-022 Arithmetic SHALL wrap modulo 2^64; SLT/SLTI signed compare, SLTU/SLTIU unsigned; result 1 or 0.
REQ-023 All other opcodes (loads, stores, branches, jumps, system, 0x00000000) SHALL assert illegal, wr_en=0, result=0.
REQ-024 Register read SHALL return pre-write value in the write cycle (no bypass); a dependent instruction in the next cycle SHALL see the new value.
REQ-025 Debug read of a register being written SHALL return old value that cycle.

Reset
REQ-026 reset=0 SHALL immediately clear x1..x31 to 0 and force wr_en=0, independent of clk.
REQ-027 A write coinciding with reset assertion SHALL be discarded; first write possible at first rising edge after reset=1.

Configuration
REQ-028 Macro RV64_WORD_OPS_EN: defined -> OP-IMM-32 (0011011: ADDIW, SLLIW, SRLIW, SRAIW) and OP-32 (0111011: ADDW, SUBW, SLLW, SRLW, SRAW) supported, computing on low 32 bits, shift amount 5 bits, result sign-extended from bit 31; shamt[5]=1 in *IW shifts illegal.
REQ-029 Macro undefined -> opcodes 0011011/0111011 SHALL be illegal with wr_en=0.

Verification
REQ-030 Reset then dbg_addr=1..31 -> dbg_data=0 for all.
REQ-031 ADDI x1,x0,-1 then SRLI x2,x1,60 -> x1=0xFFFFFFFFFFFFFFFF, x2=0xF; SRAI x3,x1,60 -> x3=all ones.
REQ-032 ADDI x5,x0,5; SUB x6,x0,x5; SLTU x7,x0,x6; SLT x8,x6,x0 -> x6=0xFFFFFFFFFFFFFFFB, x7=1, x8=1.
REQ-033 LUI x9,0x80000 -> x9=0xFFFFFFFF80000000; AUIPC x10,1 with pc=0x1000 -> x10=0x2000.
REQ-034 ADDI x0,x0,7 -> wr_en=0, x0 reads 0; instruction 0x00000000 -> illegal=1, no write.
REQ-035 With RV64_WORD_OPS_EN: x1=0x7FFFFFFF, ADDIW x2,x1,1 -> x2=0xFFFFFFFF80000000; without macro same instruction -> illegal=1, x2 unchanged.

Source files
------------

// File: rtl/decode_exec_unit.sv
// decode_exec_unit
//   Single-cycle RV64I integer decode/execute slice with a 32 x 64-bit
//   architectural register file. Decode, register read and the ALU are
//   combinational; the result is written back on the rising edge that closes
//   the cycle in which instr_valid is high.
//
//   Optional feature macro: RV64_WORD_OPS_EN
//     defined   -> OP-IMM-32 (ADDIW/SLLIW/SRLIW/SRAIW) and
//                  OP-32 (ADDW/SUBW/SLLW/SRLW/SRAW) are executed
//     undefined -> those two opcodes decode as illegal
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous active-low reset, clears x1..x31
//   instr_valid  instruction present this cycle
//   instruction  32-bit RV64I instruction word
//   pc           instruction address (used by AUIPC)
//   dbg_addr     debug register read index
//   dbg_data     combinational value of register dbg_addr
//   rd/rs1/rs2   decoded register fields
//   immediate    sign-extended I- or U-type immediate (0 for other opcodes)
//   alu_op       {instruction[30], funct3, opcode}
//   shamt        instruction[25:20]
//   result       combinational ALU result (0 when the encoding is illegal)
//   wr_en        a register write happens at the next rising edge
//   illegal      instr_valid with an unsupported encoding
module decode_exec_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid,
  input  logic [31:0] instruction,
  input  logic [63:0] pc,
  input  logic [4:0]  dbg_addr,
  output logic [63:0] dbg_data,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [31:0] immediate,
  output logic [10:0] alu_op,
  output logic [5:0]  shamt,
  output logic [63:0] result,
  output logic        wr_en,
  output logic        illegal
);

  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
`ifdef RV64_WORD_OPS_EN
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;

  function automatic logic [63:0] sext32(input logic [31:0] w);
    return {{32{w[31]}}, w};
  endfunction
`endif

  logic [63:0] regs_r [0:31];
  logic [6:0]  opcode_s;
  logic [2:0]  funct3_s;
  logic [6:0]  funct7_s;
  logic [63:0] src1_s;
  logic [63:0] src2_s;
  logic [63:0] imm_i_s;
  logic [63:0] imm_u_s;
  logic [63:0] alu_s;
  logic        legal_s;
`ifdef RV64_WORD_OPS_EN
  logic [31:0] word_s;
`endif

  assign opcode_s = instruction[6:0];
  assign funct3_s = instruction[14:12];
  assign funct7_s = instruction[31:25];
  assign rd       = instruction[11:7];
  assign rs1      = instruction[19:15];
  assign rs2      = instruction[24:20];
  assign shamt    = instruction[25:20];
  assign alu_op   = {instruction[30], funct3_s, opcode_s};
  assign imm_i_s  = {{52{instruction[31]}}, instruction[31:20]};
  assign imm_u_s  = {{32{instruction[31]}}, instruction[31:12], 12'h000};

  // x0 is hard-wired to zero; reads are never bypassed from a pending write.
  assign src1_s   = (rs1 == 5'd0)      ? 64'd0 : regs_r[rs1];
  assign src2_s   = (rs2 == 5'd0)      ? 64'd0 : regs_r[rs2];
  assign dbg_data = (dbg_addr == 5'd0) ? 64'd0 : regs_r[dbg_addr];

  // reset appears in the data path so that asserting it kills a write at once.
  assign illegal = instr_valid & ~legal_s;
  assign wr_en   = instr_valid & legal_s & (rd != 5'd0) & reset;

  // Combinational decode and ALU; illegal encodings produce a zero result.
  always_comb begin
    legal_s   = 1'b0;
    alu_s     = 64'd0;
    immediate = 32'd0;
`ifdef RV64_WORD_OPS_EN
    word_s    = 32'd0;
`endif
    case (opcode_s)
      OPC_OP_IMM: begin
        immediate = imm_i_s[31:0];
        case (funct3_s)
          3'b000: begin legal_s = 1'b1; alu_s = src1_s + imm_i_s; end
          3'b010: begin legal_s = 1'b1; alu_s = ($signed(src1_s) < $signed(imm_i_s)) ? 64'd1 : 64'd0; end
          3'b011: begin legal_s = 1'b1; alu_s = (src1_s < imm_i_s) ? 64'd1 : 64'd0; end
          3'b100: begin legal_s = 1'b1; alu_s = src1_s ^ imm_i_s; end
          3'b110: begin legal_s = 1'b1; alu_s = src1_s | imm_i_s; end
          3'b111: begin legal_s = 1'b1; alu_s = src1_s & imm_i_s; end
          3'b001: begin
            legal_s = (instruction[31:26] == 6'b000000);
            alu_s   = src1_s << shamt;
          end
          3'b101: begin
            if (instruction[31:26] == 6'b000000) begin
              legal_s = 1'b1;
              alu_s   = src1_s >> shamt;
            end else if (instruction[31:26] == 6'b010000) begin
              legal_s = 1'b1;
              alu_s   = $signed(src1_s) >>> shamt;
            end else begin
              legal_s = 1'b0;
            end
          end
          default: legal_s = 1'b0;
        endcase
      end
      OPC_OP: begin
        legal_s = 1'b1;
        case ({funct7_s, funct3_s})
          {7'b0000000, 3'b000}: alu_s = src1_s + src2_s;
          {7'b0100000, 3'b000}: alu_s = src1_s - src2_s;
          {7'b0000000, 3'b001}: alu_s = src1_s << src2_s[5:0];
          {7'b0000000, 3'b010}: alu_s = ($signed(src1_s) < $signed(src2_s)) ? 64'd1 : 64'd0;
          {7'b0000000, 3'b011}: alu_s = (src1_s < src2_s) ? 64'd1 : 64'd0;
          {7'b0000000, 3'b100}: alu_s = src1_s ^ src2_s;
          {7'b0000000, 3'b101}: alu_s = src1_s >> src2_s[5:0];
          {7'b0100000, 3'b101}: alu_s = $signed(src1_s) >>> src2_s[5:0];
          {7'b0000000, 3'b110}: alu_s = src1_s | src2_s;
          {7'b0000000, 3'b111}: alu_s = src1_s & src2_s;
          default:              legal_s = 1'b0;
        endcase
      end
      OPC_LUI: begin
        immediate = imm_u_s[31:0];
        legal_s   = 1'b1;
        alu_s     = imm_u_s;
      end
      OPC_AUIPC: begin
        immediate = imm_u_s[31:0];
        legal_s   = 1'b1;
        alu_s     = pc + imm_u_s;
      end
`ifdef RV64_WORD_OPS_EN
      // Word ops: 32-bit arithmetic with 5-bit shift amounts, sign-extended.
      // funct7 covers shamt[5], so shamt[5]=1 falls out as illegal here.
      OPC_OP_IMM_32: begin
        immediate = imm_i_s[31:0];
        case ({funct7_s, funct3_s})
          {7'b0000000, 3'b001}: begin legal_s = 1'b1; word_s = src1_s[31:0] << instruction[24:20]; end
          {7'b0000000, 3'b101}: begin legal_s = 1'b1; word_s = src1_s[31:0] >> instruction[24:20]; end
          {7'b0100000, 3'b101}: begin legal_s = 1'b1; word_s = $signed(src1_s[31:0]) >>> instruction[24:20]; end
          default: begin
            if (funct3_s == 3'b000) begin
              legal_s = 1'b1;
              word_s  = src1_s[31:0] + imm_i_s[31:0];
            end else begin
              legal_s = 1'b0;
            end
          end
        endcase
        alu_s = sext32(word_s);
      end
      OPC_OP_32: begin
        legal_s = 1'b1;
        case ({funct7_s, funct3_s})
          {7'b0000000, 3'b000}: word_s = src1_s[31:0] + src2_s[31:0];
          {7'b0100000, 3'b000}: word_s = src1_s[31:0] - src2_s[31:0];
          {7'b0000000, 3'b001}: word_s = src1_s[31:0] << src2_s[4:0];
          {7'b0000000, 3'b101}: word_s = src1_s[31:0] >> src2_s[4:0];
          {7'b0100000, 3'b101}: word_s = $signed(src1_s[31:0]) >>> src2_s[4:0];
          default:              legal_s = 1'b0;
        endcase
        alu_s = sext32(word_s);
      end
`endif
      default: legal_s = 1'b0;
    endcase

    if (legal_s) begin
      result = alu_s;
    end else begin
      result = 64'd0;
    end
  end

  // Register file write-back; reset clears every entry without waiting for clk.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) begin
        regs_r[i] <= 64'd0;
      end
    end else if (wr_en) begin
      regs_r[rd] <= result;
    end
  end

endmodule

// File: tb/tb_decode_exec_unit.sv
module tb_decode_exec_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic [31:0] instruction;
  logic [63:0] pc;
  logic [4:0]  dbg_addr;
  logic [63:0] dbg_data;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] immediate;
  logic [10:0] alu_op;
  logic [5:0]  shamt;
  logic [63:0] result;
  logic        wr_en;
  logic        illegal;

  decode_exec_unit dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instruction(instruction),
    .pc(pc), .dbg_addr(dbg_addr), .dbg_data(dbg_data), .rd(rd), .rs1(rs1), .rs2(rs2),
    .immediate(immediate), .alu_op(alu_op), .shamt(shamt), .result(result),
    .wr_en(wr_en), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] result;
    logic        wr_en;
    logic        illegal;
    logic [63:0] dbg;
    logic [31:0] imm;
    logic [5:0]  shamt;
  } exp_t;

  exp_t        sb_q[$];
  logic [63:0] m_regs [0:31];
  int          checks = 0;
  int          errors = 0;

  localparam logic [6:0] OPIMM = 7'b0010011;
  localparam logic [6:0] OP    = 7'b0110011;
  localparam logic [6:0] LUI   = 7'b0110111;
  localparam logic [6:0] AUIPC = 7'b0010111;
  localparam logic [6:0] OPIW  = 7'b0011011;
  localparam logic [6:0] OPW   = 7'b0111011;

  function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [4:0] s1,
                                         input logic [2:0] f3, input logic [4:0] d, input logic [6:0] op);
    return {imm, s1, f3, d, op};
  endfunction

  function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] s2, input logic [4:0] s1,
                                         input logic [2:0] f3, input logic [4:0] d, input logic [6:0] op);
    return {f7, s2, s1, f3, d, op};
  endfunction

  function automatic logic [31:0] u_type(input logic [19:0] imm, input logic [4:0] d, input logic [6:0] op);
    return {imm, d, op};
  endfunction

  // Reference model: RV64I semantics on the bench's own register array.
  task automatic ref_exec(input logic [31:0] ins, input logic [63:0] pcv,
                          output logic [63:0] res, output logic ok, output logic [31:0] imm);
    logic [63:0] a, b, ii, uu;
    longint      sa, sb, si;
    logic [31:0] w;
    logic [6:0]  op, f7;
    logic [2:0]  f3;
    a  = m_regs[ins[19:15]];
    b  = m_regs[ins[24:20]];
    ii = {{52{ins[31]}}, ins[31:20]};
    uu = {{32{ins[31]}}, ins[31:12], 12'h000};
    sa = a; sb = b; si = ii;
    op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
    res = 64'd0; ok = 1'b0; imm = 32'd0; w = 32'd0;
    if (op == OPIMM) begin
      imm = ii[31:0]; ok = 1'b1;
      case (f3)
        3'd0: res = a + ii;
        3'd2: res = (sa < si) ? 64'd1 : 64'd0;
        3'd3: res = (a < ii) ? 64'd1 : 64'd0;
        3'd4: res = a ^ ii;
        3'd6: res = a | ii;
        3'd7: res = a & ii;
        3'd1: begin ok = (ins[31:26] == 6'd0); res = a << ins[25:20]; end
        default: begin
          if (ins[31:26] == 6'd0) res = a >> ins[25:20];
          else if (ins[31:26] == 6'h10) res = sa >>> ins[25:20];
          else ok = 1'b0;
        end
      endcase
    end else if (op == OP) begin
      ok = 1'b1;
      if (f7 == 7'h00) begin
        case (f3)
          3'd0: res = a + b;
          3'd1: res = a << b[5:0];
          3'd2: res = (sa < sb) ? 64'd1 : 64'd0;
          3'd3: res = (a < b) ? 64'd1 : 64'd0;
          3'd4: res = a ^ b;
          3'd5: res = a >> b[5:0];
          3'd6: res = a | b;
          default: res = a & b;
        endcase
      end else if (f7 == 7'h20 && f3 == 3'd0) res = a - b;
      else if (f7 == 7'h20 && f3 == 3'd5) res = sa >>> b[5:0];
      else ok = 1'b0;
    end else if (op == LUI) begin
      imm = uu[31:0]; ok = 1'b1; res = uu;
    end else if (op == AUIPC) begin
      imm = uu[31:0]; ok = 1'b1; res = pcv + uu;
    end
`ifdef RV64_WORD_OPS_EN
    else if (op == OPIW) begin
      imm = ii[31:0]; ok = 1'b1;
      if (f3 == 3'd0) w = a[31:0] + ii[31:0];
      else if (f3 == 3'd1 && f7 == 7'h00) w = a[31:0] << ins[24:20];
      else if (f3 == 3'd5 && f7 == 7'h00) w = a[31:0] >> ins[24:20];
      else if (f3 == 3'd5 && f7 == 7'h20) w = $signed(a[31:0]) >>> ins[24:20];
      else ok = 1'b0;
      res = {{32{w[31]}}, w};
    end else if (op == OPW) begin
      ok = 1'b1;
      if (f3 == 3'd0 && f7 == 7'h00) w = a[31:0] + b[31:0];
      else if (f3 == 3'd0 && f7 == 7'h20) w = a[31:0] - b[31:0];
      else if (f3 == 3'd1 && f7 == 7'h00) w = a[31:0] << b[4:0];
      else if (f3 == 3'd5 && f7 == 7'h00) w = a[31:0] >> b[4:0];
      else if (f3 == 3'd5 && f7 == 7'h20) w = $signed(a[31:0]) >>> b[4:0];
      else ok = 1'b0;
      res = {{32{w[31]}}, w};
    end
`endif
    if (!ok) res = 64'd0;
  endtask

  // Drive one instruction, push its expected response, then update the model.
  task automatic issue(input logic [31:0] ins, input logic [63:0] pcv, input logic [4:0] da);
    exp_t        e;
    logic [63:0] res;
    logic        ok;
    logic [31:0] imm;
    @(posedge clk); #1;
    instruction = ins; pc = pcv; dbg_addr = da; instr_valid = 1'b1;
    ref_exec(ins, pcv, res, ok, imm);
    e.result  = res;
    e.illegal = !ok;
    e.wr_en   = ok && (ins[11:7] != 5'd0);
    e.dbg     = m_regs[da];
    e.imm     = imm;
    e.shamt   = ins[25:20];
    sb_q.push_back(e);
    if (e.wr_en) m_regs[ins[11:7]] = res;
  endtask

  // Debug read against a fixed value, riding on an all-zero (illegal) word.
  task automatic dbg_check(input logic [4:0] da, input logic [63:0] val);
    exp_t e;
    @(posedge clk); #1;
    instruction = 32'd0; pc = 64'd0; dbg_addr = da; instr_valid = 1'b1;
    e.result = 64'd0; e.illegal = 1'b1; e.wr_en = 1'b0;
    e.dbg = val; e.imm = 32'd0; e.shamt = 6'd0;
    sb_q.push_back(e);
  endtask

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every valid cycle pops one expectation and compares outputs.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (instr_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL scoreboard_underflow: got output with empty queue (t=%0t)", $time);
      end else begin
        e = sb_q.pop_front();
        cmp("result",    result,           e.result);
        cmp("wr_en",     {63'd0, wr_en},   {63'd0, e.wr_en});
        cmp("illegal",   {63'd0, illegal}, {63'd0, e.illegal});
        cmp("dbg_data",  dbg_data,         e.dbg);
        cmp("immediate", {32'd0, immediate}, {32'd0, e.imm});
        cmp("shamt",     {58'd0, shamt},   {58'd0, e.shamt});
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    exp_t        e;
    logic [31:0] ins;
    logic [6:0]  op, f7;
    logic [6:0]  ops [10];
    int          sel;
    ops = '{OPIMM, OPIMM, OP, OP, LUI, AUIPC, OPIW, OPW, 7'b0000011, 7'b1100011};
    for (int i = 0; i < 32; i++) m_regs[i] = 64'd0;
    reset = 1'b1; instr_valid = 1'b0; instruction = 32'd0; pc = 64'd0; dbg_addr = 5'd0;
    #2 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // Reset state of every register
    for (int i = 1; i < 32; i++) dbg_check(i[4:0], 64'd0);

    // Shifts of an all-ones value
    issue(i_type(12'hFFF, 5'd0, 3'd0, 5'd1, OPIMM), 64'd0, 5'd1);
    issue(i_type({6'b000000, 6'd60}, 5'd1, 3'd5, 5'd2, OPIMM), 64'd0, 5'd1);
    issue(i_type({6'b010000, 6'd60}, 5'd1, 3'd5, 5'd3, OPIMM), 64'd0, 5'd2);
    dbg_check(5'd1, 64'hFFFF_FFFF_FFFF_FFFF);
    dbg_check(5'd2, 64'h0000_0000_0000_000F);
    dbg_check(5'd3, 64'hFFFF_FFFF_FFFF_FFFF);

    // Subtract and signed/unsigned compare
    issue(i_type(12'd5, 5'd0, 3'd0, 5'd5, OPIMM), 64'd0, 5'd0);
    issue(r_type(7'h20, 5'd5, 5'd0, 3'd0, 5'd6, OP), 64'd0, 5'd5);
    issue(r_type(7'h00, 5'd6, 5'd0, 3'd3, 5'd7, OP), 64'd0, 5'd6);
    issue(r_type(7'h00, 5'd0, 5'd6, 3'd2, 5'd8, OP), 64'd0, 5'd7);
    dbg_check(5'd6, 64'hFFFF_FFFF_FFFF_FFFB);
    dbg_check(5'd7, 64'd1);
    dbg_check(5'd8, 64'd1);

    // Upper immediates
    issue(u_type(20'h80000, 5'd9, LUI), 64'd0, 5'd9);
    issue(u_type(20'h00001, 5'd10, AUIPC), 64'h1000, 5'd10);
    dbg_check(5'd9,  64'hFFFF_FFFF_8000_0000);
    dbg_check(5'd10, 64'h0000_0000_0000_2000);

    // x0 is never written; all-zero word is illegal
    issue(i_type(12'd7, 5'd0, 3'd0, 5'd0, OPIMM), 64'd0, 5'd0);
    dbg_check(5'd0, 64'd0);
    issue(32'h0000_0000, 64'd0, 5'd0);

    // ADDIW overflow (or illegal without word ops); same-cycle debug sees old x2
    issue(i_type(12'hFFF, 5'd0, 3'd0, 5'd1, OPIMM), 64'd0, 5'd0);
    issue(i_type({6'b000000, 6'd33}, 5'd1, 3'd5, 5'd1, OPIMM), 64'd0, 5'd0);
    issue(i_type(12'd3, 5'd0, 3'd0, 5'd2, OPIMM), 64'd0, 5'd0);
    dbg_check(5'd1, 64'h0000_0000_7FFF_FFFF);
    issue(i_type(12'd1, 5'd1, 3'd0, 5'd2, OPIW), 64'd0, 5'd2);
`ifdef RV64_WORD_OPS_EN
    dbg_check(5'd2, 64'hFFFF_FFFF_8000_0000);
`else
    dbg_check(5'd2, 64'd3);
`endif

    // Randomized mix with small register indices to create dependencies
    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        @(posedge clk); #1 instr_valid = 1'b0;
      end else begin
        op  = ops[$urandom_range(0, 9)];
        sel = $urandom_range(0, 9);
        f7  = (sel < 5) ? 7'h00 : (sel < 8) ? 7'h20 : 7'($urandom);
        if ((op == OPIMM || op == OPIW) && sel < 8) f7[0] = 1'($urandom);
        ins = {f7, 5'($urandom), 5'($urandom_range(0, 7)), 3'($urandom),
               5'($urandom_range(0, 7)), op};
        if (op == OPIMM && $urandom_range(0, 1) == 1) ins[31:20] = 12'($urandom);
        issue(ins, {32'($urandom), 32'($urandom)}, 5'($urandom_range(0, 8)));
      end
    end

    // Reset asserted during a writing instruction: write dropped, state cleared
    issue(i_type(12'd1, 5'd0, 3'd0, 5'd1, OPIMM), 64'd0, 5'd1);
    @(posedge clk); #1;
    instruction = i_type(12'h123, 5'd0, 3'd0, 5'd4, OPIMM);
    dbg_addr = 5'd1; instr_valid = 1'b1; reset = 1'b0;
    for (int i = 0; i < 32; i++) m_regs[i] = 64'd0;
    e.result = 64'h123; e.wr_en = 1'b0; e.illegal = 1'b0;
    e.dbg = 64'd0; e.imm = 32'h123; e.shamt = 6'h23;
    sb_q.push_back(e);
    @(posedge clk); #1;
    instr_valid = 1'b0; reset = 1'b1;
    dbg_check(5'd4, 64'd0);
    dbg_check(5'd1, 64'd0);
    issue(i_type(12'h456, 5'd0, 3'd0, 5'd4, OPIMM), 64'd0, 5'd4);
    dbg_check(5'd4, 64'h456);

    @(posedge clk); #1 instr_valid = 1'b0;
    repeat (3) @(posedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
